writeback_arbiter: RTL

Consumer end of the issue/execute result interface. Accepts the three registered execution result streams (ALU, load/store, branch) each cycle and buffers them in per-lane FIFOs. It arbitrates them onto a limited number of physical-register-file write / ROB completion ports, and raises a registered branch redirect. It sits between the execute output registers and the physical register file, wakeup broadcast and ROB.

---
 rtl/writeback_arbiter_pkg.sv | 22 ++
 rtl/writeback_arbiter_lane_fifo.sv | 58 +++++
 rtl/writeback_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared lane encoding, default sizing and lane rotation helper for the writeback arbiter.
package writeback_arbiter_pkg;

    localparam int unsigned WB_PORTS_DEFAULT      = 2;
    localparam int unsigned WB_FIFO_DEPTH_DEFAULT = 4;
    localparam int unsigned NUM_LANES             = 3;

    typedef enum logic [1:0] {
        LANE_ALU = 2'd0,
        LANE_LS  = 2'd1,
        LANE_BR  = 2'd2
    } lane_e;

    function automatic lane_e next_lane(input lane_e l);
        case (l)
            LANE_ALU: return LANE_LS;
            LANE_LS:  return LANE_BR;
            default:  return LANE_ALU;
        endcase
    endfunction

endpackage

// File: rtl/writeback_arbiter_lane_fifo.sv
// wb_lane_fifo: single-lane result buffer; pointers wrap naturally, a same-edge pop frees room for a push.
module wb_lane_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!i_flush && w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Buffers ALU/LS/BR results and round-robins them onto WB_PORTS writeback ports with a registered redirect.
// Optional WRITEBACK_BYPASS_EN lets a valid input on an empty lane compete for a port in the same cycle.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned PHY_WIDTH  = 6,
    parameter int unsigned ROB_WIDTH  = 5,
    parameter int unsigned WB_PORTS   = WB_PORTS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             alu_valid,
    input  logic [ROB_WIDTH-1:0]             alu_rob_id,
    input  logic [PHY_WIDTH-1:0]             alu_rd_phy,
    input  logic [DATA_WIDTH-1:0]            alu_data,
    input  logic                             ls_valid,
    input  logic [ROB_WIDTH-1:0]             ls_rob_id,
    input  logic [PHY_WIDTH-1:0]             ls_rd_phy,
    input  logic [DATA_WIDTH-1:0]            ls_data,
    input  logic                             ls_is_store,
    input  logic                             br_valid,
    input  logic [ROB_WIDTH-1:0]             br_rob_id,
    input  logic [PHY_WIDTH-1:0]             br_rd_phy,
    input  logic [ADDR_WIDTH-1:0]            br_next_pc,
    input  logic [ADDR_WIDTH-1:0]            br_jump_pc,
    input  logic                             br_is_jump,
    output logic                             alu_ready,
    output logic                             ls_ready,
    output logic                             br_ready,
    output logic [WB_PORTS-1:0]              wb_valid,
    output logic [WB_PORTS-1:0]              wb_we,
    output logic [WB_PORTS*PHY_WIDTH-1:0]    wb_rd_phy,
    output logic [WB_PORTS*DATA_WIDTH-1:0]   wb_data,
    output logic [WB_PORTS*ROB_WIDTH-1:0]    wb_rob_id,
    output logic                             redirect_valid,
    output logic [ADDR_WIDTH-1:0]            redirect_pc,
    output logic                             overflow_err
);

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  rob_id;
        logic [PHY_WIDTH-1:0]  rd_phy;
        logic [DATA_WIDTH-1:0] data;
        logic                  is_store;
        logic                  is_jump;
        logic [ADDR_WIDTH-1:0] jump_pc;
    } WB_ENTRY_t;

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0]  PORTS_N = 2'(WB_PORTS);

    WB_ENTRY_t   w_in   [NUM_LANES];
    WB_ENTRY_t   w_head [NUM_LANES];
    WB_ENTRY_t   w_cand [NUM_LANES];
    logic [CW-1:0] w_count [NUM_LANES];
    logic [1:0]  w_slot [NUM_LANES];
    logic [2:0]  w_in_valid, w_empty, w_full, w_byp, w_cand_valid;
    logic [2:0]  w_grant, w_push, w_pop, w_drop;
    logic [1:0]  w_scan_n;
    lane_e       w_scan_lane, w_rr_next, r_rr;

    logic [WB_PORTS-1:0]            w_nx_valid, w_nx_we, r_wb_valid, r_wb_we;
    logic [WB_PORTS*PHY_WIDTH-1:0]  w_nx_rd, r_wb_rd_phy;
    logic [WB_PORTS*DATA_WIDTH-1:0] w_nx_data, r_wb_data;
    logic [WB_PORTS*ROB_WIDTH-1:0]  w_nx_rob, r_wb_rob_id;
    logic                           w_nx_redir, r_redirect_valid, r_overflow_err;
    logic [ADDR_WIDTH-1:0]          w_nx_pc, r_redirect_pc;

    always_comb begin
        w_in[0] = '{rob_id: alu_rob_id, rd_phy: alu_rd_phy, data: alu_data,
                    is_store: 1'b0, is_jump: 1'b0, jump_pc: '0};
        w_in[1] = '{rob_id: ls_rob_id, rd_phy: ls_rd_phy, data: ls_data,
                    is_store: ls_is_store, is_jump: 1'b0, jump_pc: '0};
        w_in[2] = '{rob_id: br_rob_id, rd_phy: br_rd_phy, data: DATA_WIDTH'(br_next_pc),
                    is_store: 1'b0, is_jump: br_is_jump, jump_pc: br_jump_pc};
    end

    // Flush drops same-edge inputs, so gate valids before they reach push or bypass.
    assign w_in_valid = {br_valid, ls_valid, alu_valid} & {3{!flush}};

`ifdef WRITEBACK_BYPASS_EN
    assign w_byp = w_empty & w_in_valid;
`else
    assign w_byp = '0;
`endif

    assign w_cand_valid = ~w_empty | w_byp;
    assign w_pop        = w_grant & ~w_empty;
    assign w_push       = w_in_valid & ~(w_byp & w_grant);
    assign w_drop       = w_push & w_full & ~w_pop;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_cand[g] = w_empty[g] ? w_in[g] : w_head[g];

        wb_lane_fifo #(
            .WIDTH ($bits(WB_ENTRY_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush),
            .i_push  (w_push[g]),
            .i_data  (w_in[g]),
            .i_pop   (w_pop[g]),
            .o_head  (w_head[g]),
            .o_count (w_count[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // Circular scan from r_rr; w_slot records which port each granted lane lands on.
    always_comb begin
        w_grant     = '0;
        w_rr_next   = r_rr;
        w_scan_n    = '0;
        w_scan_lane = r_rr;
        for (int unsigned j = 0; j < NUM_LANES; j++) w_slot[j] = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (w_cand_valid[w_scan_lane] && (w_scan_n < PORTS_N)) begin
                w_grant[w_scan_lane] = 1'b1;
                w_slot[w_scan_lane]  = w_scan_n;
                w_scan_n             = w_scan_n + 2'd1;
                w_rr_next            = next_lane(w_scan_lane);
            end
            w_scan_lane = next_lane(w_scan_lane);
        end
    end

    always_comb begin
        w_nx_valid = '0;
        w_nx_we    = '0;
        w_nx_rd    = '0;
        w_nx_data  = '0;
        w_nx_rob   = '0;
        w_nx_redir = 1'b0;
        w_nx_pc    = '0;
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            for (int unsigned j = 0; j < NUM_LANES; j++) begin
                if (w_grant[j[1:0]] && (w_slot[j[1:0]] == p[1:0])) begin
                    w_nx_valid[p] = 1'b1;
                    w_nx_we[p]    = (w_cand[j[1:0]].rd_phy != '0) && !w_cand[j[1:0]].is_store;
                    w_nx_rd[p*PHY_WIDTH +: PHY_WIDTH]    = w_cand[j[1:0]].rd_phy;
                    w_nx_data[p*DATA_WIDTH +: DATA_WIDTH] = w_cand[j[1:0]].data;
                    w_nx_rob[p*ROB_WIDTH +: ROB_WIDTH]    = w_cand[j[1:0]].rob_id;
                    if (w_cand[j[1:0]].is_jump) begin
                        w_nx_redir = 1'b1;
                        w_nx_pc    = w_cand[j[1:0]].jump_pc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr             <= LANE_ALU;
            r_wb_valid       <= '0;
            r_wb_we          <= '0;
            r_wb_rd_phy      <= '0;
            r_wb_data        <= '0;
            r_wb_rob_id      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (flush) begin
            r_rr             <= LANE_ALU;
            r_wb_valid       <= '0;
            r_wb_we          <= '0;
            r_wb_rd_phy      <= '0;
            r_wb_data        <= '0;
            r_wb_rob_id      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_rr             <= w_rr_next;
            r_wb_valid       <= w_nx_valid;
            r_wb_we          <= w_nx_we;
            r_wb_rd_phy      <= w_nx_rd;
            r_wb_data        <= w_nx_data;
            r_wb_rob_id      <= w_nx_rob;
            r_redirect_valid <= w_nx_redir;
            r_redirect_pc    <= w_nx_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_overflow_err <= 1'b0;
        else if (|w_drop) r_overflow_err <= 1'b1;
    end

    assign alu_ready      = (w_count[0] <= CW'(FIFO_DEPTH - 2));
    assign ls_ready       = (w_count[1] <= CW'(FIFO_DEPTH - 2));
    assign br_ready       = (w_count[2] <= CW'(FIFO_DEPTH - 2));
    assign wb_valid       = r_wb_valid;
    assign wb_we          = r_wb_we;
    assign wb_rd_phy      = r_wb_rd_phy;
    assign wb_data        = r_wb_data;
    assign wb_rob_id      = r_wb_rob_id;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign overflow_err   = r_overflow_err;

endmodule
